// File: rtl/tbec_read_arbiter.sv
// tbec_read_arbiter: round-robin arbiter sharing one memory read port and one TBEC-RSC decoder.
// Optional macro TBEC_ERR_LOG_EN adds err_addr/err_id capture of the last corrected read.
module tbec_read_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [0:31]       mem_rdata,
  output logic [0:31]       dec_cw,
  input  logic [0:15]       dec_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [0:15]       rsp_data,
  output logic              rsp_id,
  output logic              rsp_corr,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              err_cnt_clr,
  output logic              busy
`ifdef TBEC_ERR_LOG_EN
  ,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_id
`endif
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DECODE, S_RESP} state_t;
  state_t r_state, w_next;
  logic w_gnt0, w_gnt1, w_corr, w_inc, w_grant;
  logic r_last, r_id, r_rsp_id, r_corr;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0] r_cnt;
  logic [0:31] r_cw;
  logic [0:15] r_data;
  logic [CNT_W-1:0] r_err;
`ifdef TBEC_ERR_LOG_EN
  logic [ADDR_W-1:0] r_err_addr;
  logic r_err_id;
  assign err_addr = r_err_addr;
  assign err_id   = r_err_id;
`endif
  // r_last is the requester granted most recently; the other one wins a tie
  always_comb begin
    w_gnt0 = req0_valid && (!req1_valid || r_last);
    w_gnt1 = req1_valid && (!req0_valid || !r_last);
    w_grant = r_state == S_IDLE && (w_gnt0 || w_gnt1);
    w_corr = dec_data != r_cw[0:15];
    w_inc = r_state == S_DECODE && w_corr && !(&r_err);
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_grant ? S_ISSUE : S_IDLE;
      S_ISSUE:  w_next = S_WAIT;
      S_WAIT:   w_next = r_cnt == 3'd1 ? S_DECODE : S_WAIT;
      S_DECODE: w_next = S_RESP;
      S_RESP:   w_next = rsp_ready ? S_IDLE : S_RESP;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_last <= 1'b1;
      r_id <= 1'b0;
      r_addr <= '0;
      r_cnt <= '0;
      r_cw <= '0;
      r_data <= '0;
      r_rsp_id <= 1'b0;
      r_corr <= 1'b0;
      r_err <= '0;
`ifdef TBEC_ERR_LOG_EN
      r_err_addr <= '0;
      r_err_id <= 1'b0;
`endif
    end else begin
      if (w_grant) begin
        r_addr <= w_gnt1 ? req1_addr : req0_addr;
        r_id <= w_gnt1;
        r_last <= w_gnt1;
      end
      if (r_state == S_ISSUE) r_cnt <= 3'(MEM_LAT);
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 3'd1;
      // the read data is only valid in the final WAIT cycle
      if (r_state == S_WAIT && r_cnt == 3'd1) r_cw <= mem_rdata;
      if (r_state == S_DECODE) begin
        r_data <= dec_data;
        r_corr <= w_corr;
        r_rsp_id <= r_id;
      end
      if (err_cnt_clr) r_err <= '0;
      else if (w_inc) r_err <= r_err + CNT_W'(1);
`ifdef TBEC_ERR_LOG_EN
      if (err_cnt_clr) begin
        r_err_addr <= '0;
        r_err_id <= 1'b0;
      end else if (r_state == S_DECODE && w_corr) begin
        r_err_addr <= r_addr;
        r_err_id <= r_id;
      end
`endif
    end
  // ready is combinational in IDLE, so keep it quiet while reset is held
  assign req0_ready = rst_n && r_state == S_IDLE && w_gnt0;
  assign req1_ready = rst_n && r_state == S_IDLE && w_gnt1;
  assign mem_en = r_state == S_ISSUE;
  assign mem_addr = r_addr;
  assign dec_cw = r_cw;
  assign rsp_valid = r_state == S_RESP;
  assign rsp_data = r_data;
  assign rsp_id = r_rsp_id;
  assign rsp_corr = r_corr;
  assign err_cnt = r_err;
  assign busy = r_state != S_IDLE;
endmodule
